// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin arbiter sharing one WIDTH-bit register between
// NREQ requesters. A grant lasts one cycle; the granted requester's data is
// captured on the following edge if it still requests, otherwise the grant aborts.
// Optional burst lock is enabled by defining REGARB_LOCK_EN (adds the Lock port).
module reg_write_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = 2
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [NREQ-1:0]       Req,
    input  logic [NREQ*WIDTH-1:0] Din,
`ifdef REGARB_LOCK_EN
    input  logic [NREQ-1:0]       Lock,
`endif
    output logic [NREQ-1:0]       Gnt,
    output logic [WIDTH-1:0]      Q,
    output logic                  Upd,
    output logic [IDW-1:0]        Owner
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state, state_n;
    logic [IDW-1:0]   ptr, ptr_n;       // last requester served; scan starts after it
    logic [IDW-1:0]   win, win_n;       // requester holding the current grant
    logic [NREQ-1:0]  gnt_n;
    logic [WIDTH-1:0] q_n;
    logic             upd_n;
    logic [IDW-1:0]   owner_n;
    logic             scan_found;
    logic [IDW-1:0]   scan_idx;

    // Round-robin scan: first asserted request from ptr+1 upward, wrapping at NREQ.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves
        // it unassigned and no latch is inferred.
        scan_found = 1'b0;
        scan_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!scan_found && Req[(int'(ptr) + k) % NREQ]) begin
                scan_found = 1'b1;
                scan_idx   = IDW'((int'(ptr) + k) % NREQ);
            end
        end
    end

    // Next-state and next-output logic; all outputs are registered from these.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        win_n   = win;
        gnt_n   = '0;
        q_n     = Q;
        upd_n   = 1'b0;
        owner_n = Owner;
        case (state)
            IDLE: begin
                if (scan_found) begin
                    win_n   = scan_idx;
                    gnt_n   = NREQ'(1) << scan_idx;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                state_n = IDLE;
                // A withdrawn request aborts: register, owner and pointer untouched.
                if (Req[win]) begin
                    q_n     = Din[win*WIDTH +: WIDTH];
                    owner_n = win;
                    upd_n   = 1'b1;
`ifdef REGARB_LOCK_EN
                    // Locked winner: park the pointer just before it so it wins again.
                    if (Lock[win])
                        ptr_n = (win == '0) ? IDW'(NREQ - 1) : win - 1'b1;
                    else
                        ptr_n = win;
`else
                    ptr_n = win;
`endif
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers with asynchronous active-high reset.
    always_ff @(posedge Clk or posedge Rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (Rst) begin
            // NOTE: the shared register bank is reset too; Q must read 0 during reset.
            state <= IDLE;
            ptr   <= IDW'(NREQ - 1);
            win   <= '0;
            Gnt   <= '0;
            Q     <= '0;
            Upd   <= 1'b0;
            Owner <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            win   <= win_n;
            Gnt   <= gnt_n;
            Q     <= q_n;
            Upd   <= upd_n;
            Owner <= owner_n;
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Testbench for reg_write_arbiter: directed scenarios plus randomized traffic,
// all compared against a transaction-level reference model kept here.
// Build with REGARB_LOCK_EN defined to exercise the burst-lock feature as well.
module tb_reg_write_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [3:0]  Req = '0;
    logic [31:0] Din = '0;
`ifdef REGARB_LOCK_EN
    logic [3:0]  Lock = '0;
`endif
    logic [3:0]  Gnt;
    logic [7:0]  Q;
    logic        Upd;
    logic [1:0]  Owner;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: pending grant flag, winner, last-served pointer, visible outputs.
    bit m_busy;
    int m_w, m_ptr, m_q, m_owner, m_upd, m_gnt;

    reg_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .Req   (Req),
        .Din   (Din),
`ifdef REGARB_LOCK_EN
        .Lock  (Lock),
`endif
        .Gnt   (Gnt),
        .Q     (Q),
        .Upd   (Upd),
        .Owner (Owner)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_w = 0; m_ptr = NREQ - 1;
        m_q = 0; m_owner = 0; m_upd = 0; m_gnt = 0;
    endtask

    // One clock edge of the reference behaviour, using the inputs present before the edge.
    task automatic model_step();
        bit lk;
        if (m_busy) begin
            m_busy = 0;
            m_gnt  = 0;
            if (Req[m_w]) begin
                m_q     = int'((Din >> (m_w * WIDTH)) & 32'hFF);
                m_owner = m_w;
                m_upd   = 1;
                lk = 1'b0;
`ifdef REGARB_LOCK_EN
                lk = Lock[m_w];
`endif
                m_ptr = lk ? (m_w + NREQ - 1) % NREQ : m_w;
            end else begin
                m_upd = 0;
            end
        end else begin
            m_upd = 0;
            if (Req != 0) begin
                for (int k = 1; k <= NREQ; k++) begin
                    if (!m_busy && Req[(m_ptr + k) % NREQ]) begin
                        m_w    = (m_ptr + k) % NREQ;
                        m_busy = 1;
                    end
                end
                m_gnt = 1 << m_w;
            end
        end
    endtask

    task automatic compare_all();
        check("gnt",     32'(Gnt),          m_gnt);
        check("q",       32'(Q),            m_q);
        check("upd",     32'(Upd),          m_upd);
        check("owner",   32'(Owner),        m_owner);
        check("onehot0", 32'($onehot0(Gnt)), 32'd1);
    endtask

    task automatic cycle();
        @(posedge Clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        model_reset();
        #1;
        check("rst_gnt",   32'(Gnt),   32'd0);
        check("rst_q",     32'(Q),     32'd0);
        check("rst_upd",   32'(Upd),   32'd0);
        check("rst_owner", 32'(Owner), 32'd0);
        @(posedge Clk);
        #1;
        Rst = 1'b0;
    endtask

    initial begin
        int      nw;
        int      exp_seq [5];
        model_reset();

        // 1: single request from requester 1
        do_reset();
        Req = 4'b0010; Din = 32'h0000_A500;
        cycle();
        check("t1_gnt", 32'(Gnt), 32'h2);
        cycle();
        check("t1_q",     32'(Q),     32'hA5);
        check("t1_upd",   32'(Upd),   32'd1);
        check("t1_owner", 32'(Owner), 32'd1);
        Req = '0;
        cycle();
        check("t1_upd_pulse", 32'(Upd), 32'd0);

        // 2: all requesting -> rotation 0,1,2,3,0
        do_reset();
        Req = 4'b1111; Din = 32'h4433_2211;
        exp_seq = '{0, 1, 2, 3, 0};
        nw = 0;
        for (int c = 0; c < 10; c++) begin
            cycle();
            if (Upd && nw < 5) begin
                check("t2_owner", 32'(Owner), exp_seq[nw]);
                check("t2_q",     32'(Q),     32'((exp_seq[nw] + 1) * 32'h11));
                nw++;
            end
        end
        check("t2_nwrites", nw, 5);
        Req = '0;
        cycle();

        // 3: abort when the winner withdraws during GRANT
        do_reset();
        Req = 4'b0100; Din = 32'h00C3_0000;
        cycle();
        check("t3_gnt", 32'(Gnt), 32'h4);
        Req = '0;
        cycle();
        check("t3_upd",   32'(Upd),   32'd0);
        check("t3_q",     32'(Q),     32'd0);
        check("t3_owner", 32'(Owner), 32'd0);
        Req = 4'b1111;
        cycle();
        check("t3_ptr_kept", 32'(Gnt), 32'h1);
        cycle();
        Req = '0;
        cycle();

        // 4: reset pulse during GRANT
        Req = 4'b0010; Din = 32'h0000_5A00;
        cycle();
        cycle();
        check("t4_pre_q", 32'(Q), 32'h5A);
        Req = 4'b0001;
        cycle();
        check("t4_gnt", 32'(Gnt), 32'h1);
        Rst = 1'b1;
        model_reset();
        #1;
        check("t4_rst_gnt",   32'(Gnt),   32'd0);
        check("t4_rst_q",     32'(Q),     32'd0);
        check("t4_rst_upd",   32'(Upd),   32'd0);
        check("t4_rst_owner", 32'(Owner), 32'd0);
        @(negedge Clk);
        Rst = 1'b0;
        Req = 4'b1000; Din = 32'h7E00_0000;
        cycle();
        check("t4_wrap_gnt", 32'(Gnt), 32'h8);
        cycle();
        check("t4_wrap_q", 32'(Q), 32'h7E);
        Req = '0;
        cycle();

`ifdef REGARB_LOCK_EN
        // 5: burst lock on requester 1
        do_reset();
        Req = 4'b1111; Din = 32'h4433_2211; Lock = 4'b0010;
        exp_seq = '{0, 1, 1, 1, 2};
        nw = 0;
        for (int c = 0; c < 10; c++) begin
            // Release the lock in the GRANT cycle of the fourth write.
            if (nw == 3 && Gnt != 0) Lock = '0;
            cycle();
            if (Upd && nw < 5) begin
                check("t5_owner", 32'(Owner), exp_seq[nw]);
                nw++;
            end
        end
        check("t5_nwrites", nw, 5);
        Req = '0;
        cycle();
`endif

        // 6: randomized traffic against the model
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            Req = 4'($urandom) | 4'($urandom);
            if (($urandom % 4) == 0) Req = 4'($urandom) & 4'($urandom);
            Din = $urandom;
`ifdef REGARB_LOCK_EN
            Lock = 4'($urandom) & 4'($urandom);
`endif
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
